// File: rtl/vrf_bank_write_scheduler.sv
// Purpose : banked VRF write-port scheduler; per-bank round-robin grant of up to BANK_WR_PORTS writes.
// Latency : wr_ready is combinational; the granted write appears on bank_* one cycle after the handshake.
// Backpr. : no request buffering; a denied or stalled producer holds addr/data until wr_ready rises.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_valid/ready  per-port writeback handshake; wr_addr/wr_data carry the destination and payload
//   bank_stall      per-bank block; a stalled bank grants nothing this cycle
//   bank_we/row/data/src  registered per-bank, per-slot write strobes (src is one-hot port, 0 when idle)
//   conflict_cnt    saturating count of cycles with at least one valid request left waiting
module vrf_bank_write_scheduler #(
    parameter int PORT_NUM       = 4,
    parameter int BANK_NUM       = 4,
    parameter int BANK_WR_PORTS  = 1,
    parameter int ADDR_WIDTH     = 6,
    parameter int BANK_SEL_WIDTH = $clog2(BANK_NUM),
    parameter int ROW_WIDTH      = ADDR_WIDTH - BANK_SEL_WIDTH,
    parameter int DATA_WIDTH     = 64
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [PORT_NUM-1:0]                                   wr_valid,
    output logic [PORT_NUM-1:0]                                   wr_ready,
    input  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]                   wr_addr,
    input  logic [PORT_NUM-1:0][DATA_WIDTH-1:0]                   wr_data,
    input  logic [BANK_NUM-1:0]                                   bank_stall,
    output logic [BANK_NUM-1:0][BANK_WR_PORTS-1:0]                bank_we,
    output logic [BANK_NUM-1:0][BANK_WR_PORTS-1:0][ROW_WIDTH-1:0] bank_row,
    output logic [BANK_NUM-1:0][BANK_WR_PORTS-1:0][DATA_WIDTH-1:0] bank_data,
    output logic [BANK_NUM-1:0][BANK_WR_PORTS-1:0][PORT_NUM-1:0]  bank_src,
    output logic [15:0]                                           conflict_cnt
);

    localparam int PTR_W = $clog2(PORT_NUM);

    logic [BANK_NUM-1:0][PTR_W-1:0]                          ptr_q;
    logic [BANK_NUM-1:0][PTR_W-1:0]                          ptr_d;
    logic [BANK_NUM-1:0][BANK_WR_PORTS-1:0]                  gnt_we;
    logic [BANK_NUM-1:0][BANK_WR_PORTS-1:0][ROW_WIDTH-1:0]   gnt_row;
    logic [BANK_NUM-1:0][BANK_WR_PORTS-1:0][DATA_WIDTH-1:0]  gnt_data;
    logic [BANK_NUM-1:0][BANK_WR_PORTS-1:0][PORT_NUM-1:0]    gnt_src;

    // Instead of a sequential scan, each requester computes its distance from
    // the bank pointer and its rank among the requesters closer to the pointer.
    // Rank is the slot number; ranks beyond the slot count are denied. The
    // granted port farthest from the pointer sets the next pointer.
    always_comb begin
        logic [PORT_NUM-1:0] req;
        int                  rel [PORT_NUM];
        int                  rank;
        int                  best;

        wr_ready = '0;
        ptr_d    = ptr_q;
        gnt_we   = '0;
        gnt_row  = '0;
        gnt_data = '0;
        gnt_src  = '0;
        req      = '0;
        rank     = 0;
        best     = 0;
        for (int p = 0; p < PORT_NUM; p++) rel[p] = 0;

        for (int b = 0; b < BANK_NUM; b++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                req[p] = wr_valid[p] && !bank_stall[b]
                         && (wr_addr[p][BANK_SEL_WIDTH-1:0] == BANK_SEL_WIDTH'(b));
                rel[p] = (p + PORT_NUM - int'(ptr_q[b])) % PORT_NUM;
            end
            best = -1;
            for (int p = 0; p < PORT_NUM; p++) begin
                rank = 0;
                for (int q = 0; q < PORT_NUM; q++) begin
                    if (req[q] && (rel[q] < rel[p])) rank = rank + 1;
                end
                if (req[p] && (rank < BANK_WR_PORTS)) begin
                    wr_ready[p] = 1'b1;
                    for (int s = 0; s < BANK_WR_PORTS; s++) begin
                        if (rank == s) begin
                            gnt_we[b][s]      = 1'b1;
                            gnt_row[b][s]     = wr_addr[p][ADDR_WIDTH-1:BANK_SEL_WIDTH];
                            gnt_data[b][s]    = wr_data[p];
                            gnt_src[b][s][p]  = 1'b1;
                        end
                    end
                    if (rel[p] > best) begin
                        best     = rel[p];
                        ptr_d[b] = PTR_W'((p + 1) % PORT_NUM);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            bank_we      <= '0;
            bank_row     <= '0;
            bank_data    <= '0;
            bank_src     <= '0;
            conflict_cnt <= '0;
        end else begin
            ptr_q     <= ptr_d;
            bank_we   <= gnt_we;
            bank_row  <= gnt_row;
            bank_data <= gnt_data;
            bank_src  <= gnt_src;
            if ((|(wr_valid & ~wr_ready)) && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vrf_bank_write_scheduler.sv
// Scoreboarded bench for the VRF bank write scheduler: two instances (one and two
// write ports per bank) share the stimulus; a queue-based reference model predicts
// grants and registered bank writes, and a negedge monitor compares them.
module tb_vrf_bank_write_scheduler;

    localparam int P   = 4;
    localparam int B   = 4;
    localparam int AW  = 6;
    localparam int DW  = 64;
    localparam int BSW = 2;
    localparam int RW  = AW - BSW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                  rst;
    logic [P-1:0]          vld;
    logic [P-1:0][AW-1:0]  addr;
    logic [P-1:0][DW-1:0]  data;
    logic [B-1:0]          stall;

    logic [P-1:0]                rdy1, rdy2;
    logic [B-1:0][0:0]           we1;
    logic [B-1:0][0:0][RW-1:0]   row1;
    logic [B-1:0][0:0][DW-1:0]   data1;
    logic [B-1:0][0:0][P-1:0]    src1;
    logic [15:0]                 cnt1;
    logic [B-1:0][1:0]           we2;
    logic [B-1:0][1:0][RW-1:0]   row2;
    logic [B-1:0][1:0][DW-1:0]   data2;
    logic [B-1:0][1:0][P-1:0]    src2;
    logic [15:0]                 cnt2;

    vrf_bank_write_scheduler #(.PORT_NUM(P), .BANK_NUM(B), .BANK_WR_PORTS(1),
                               .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut1 (
        .clk(clk), .rst(rst), .wr_valid(vld), .wr_ready(rdy1), .wr_addr(addr),
        .wr_data(data), .bank_stall(stall), .bank_we(we1), .bank_row(row1),
        .bank_data(data1), .bank_src(src1), .conflict_cnt(cnt1));

    vrf_bank_write_scheduler #(.PORT_NUM(P), .BANK_NUM(B), .BANK_WR_PORTS(2),
                               .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut2 (
        .clk(clk), .rst(rst), .wr_valid(vld), .wr_ready(rdy2), .wr_addr(addr),
        .wr_data(data), .bank_stall(stall), .bank_we(we2), .bank_row(row2),
        .bank_data(data2), .bank_src(src2), .conflict_cnt(cnt2));

    // Expected records, sized for the two-slot instance; the one-slot instance
    // uses the low part (slot index b*W+s packs densely for either W).
    typedef struct {
        int               tag;
        logic [B*2-1:0]    we;
        logic [B*2*RW-1:0] row;
        logic [B*2*DW-1:0] dat;
        logic [B*2*P-1:0]  src;
        logic [15:0]       cnt;
    } orec_t;

    typedef struct {
        int           tag;
        bit           chk;
        logic [P-1:0] r0;
        logic [P-1:0] r1;
    } rrec_t;

    orec_t oq0[$];
    orec_t oq1[$];
    rrec_t rq[$];

    int mptr [2][B];
    int mcnt [2];
    logic [P-1:0] last_r0, last_r1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    // Reference: list the requesters of each bank in round-robin order starting
    // at the bank pointer; the first W of that list get slots 0..W-1.
    task automatic model_step(input int ci, output logic [P-1:0] r, output orec_t o);
        int w;
        int p;
        int n;
        int lst[$];
        w = ci + 1;
        r = '0;
        o.tag = cyc; o.we = '0; o.row = '0; o.dat = '0; o.src = '0;
        for (int b = 0; b < B; b++) begin
            lst = {};
            for (int k = 0; k < P; k++) begin
                p = (mptr[ci][b] + k) % P;
                if (vld[p] && !stall[b] && int'(addr[p][BSW-1:0]) == b) lst.push_back(p);
            end
            n = (lst.size() < w) ? lst.size() : w;
            for (int s = 0; s < n; s++) begin
                p = lst[s];
                r[p] = 1'b1;
                if (!rst) begin
                    o.we[b*w+s]             = 1'b1;
                    o.row[(b*w+s)*RW +: RW] = addr[p][AW-1:BSW];
                    o.dat[(b*w+s)*DW +: DW] = data[p];
                    o.src[(b*w+s)*P + p]    = 1'b1;
                end
            end
            if (rst) mptr[ci][b] = 0;
            else if (n > 0) mptr[ci][b] = (lst[n-1] + 1) % P;
        end
        if (rst) mcnt[ci] = 0;
        else if (((vld & ~r) != '0) && mcnt[ci] < 65535) mcnt[ci] = mcnt[ci] + 1;
        o.cnt = 16'(mcnt[ci]);
    endtask

    task automatic step(input bit chk);
        logic [P-1:0] r0, r1;
        orec_t o0, o1;
        rrec_t rr;
        model_step(0, r0, o0);
        model_step(1, r1, o1);
        last_r0 = r0;
        last_r1 = r1;
        if (chk) begin
            rr.tag = cyc; rr.chk = !rst; rr.r0 = r0; rr.r1 = r1;
            rq.push_back(rr);
            oq0.push_back(o0);
            oq1.push_back(o1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = '0; stall = '0;
        step(1);
        rst = 1'b0;
    endtask

    rrec_t mrr;
    orec_t mo;
    always @(negedge clk) begin
        if (rq.size() > 0 && rq[0].tag == cyc) begin
            mrr = rq.pop_front();
            if (mrr.chk) begin
                check("ready_w1", 512'(rdy1), 512'(mrr.r0));
                check("ready_w2", 512'(rdy2), 512'(mrr.r1));
            end
        end
        if (oq0.size() > 0 && oq0[0].tag == cyc - 1) begin
            mo = oq0.pop_front();
            check("we_w1",   512'(we1),   512'(mo.we[B-1:0]));
            check("row_w1",  512'(row1),  512'(mo.row[B*RW-1:0]));
            check("data_w1", 512'(data1), 512'(mo.dat[B*DW-1:0]));
            check("src_w1",  512'(src1),  512'(mo.src[B*P-1:0]));
            check("cnt_w1",  512'(cnt1),  512'(mo.cnt));
        end
        if (oq1.size() > 0 && oq1[0].tag == cyc - 1) begin
            mo = oq1.pop_front();
            check("we_w2",   512'(we2),   512'(mo.we));
            check("row_w2",  512'(row2),  512'(mo.row));
            check("data_w2", 512'(data2), 512'(mo.dat));
            check("src_w2",  512'(src2),  512'(mo.src));
            check("cnt_w2",  512'(cnt2),  512'(mo.cnt));
        end
    end

    initial begin
        rst = 1'b1; vld = '0; addr = '0; data = '0; stall = '0;
        last_r0 = '0; last_r1 = '0;
        for (int c = 0; c < 2; c++) begin
            mcnt[c] = 0;
            for (int b = 0; b < B; b++) mptr[c][b] = 0;
        end
        @(posedge clk);
        #1;

        // Reset held two cycles with every port requesting; writes are dropped.
        vld = '1;
        for (int p = 0; p < P; p++) begin
            addr[p] = AW'($urandom());
            data[p] = {$urandom(), $urandom()};
        end
        step(1); step(1);
        rst = 1'b0;
        for (int p = 0; p < P; p++) addr[p] = '0;
        step(1);
        vld = '0; step(1);

        // One port per bank: everything granted at once, rows 0.
        do_reset();
        for (int p = 0; p < P; p++) begin
            addr[p] = AW'(p);
            data[p] = {$urandom(), $urandom()};
        end
        vld = '1; step(1);
        vld = '0; step(1);

        // All ports to addr 4 (bank 0, row 1), held valid.
        do_reset();
        for (int p = 0; p < P; p++) addr[p] = AW'(4);
        vld = '1;
        for (int i = 0; i < 5; i++) step(1);
        vld = '0; step(1);

        // All ports to bank 1; two-slot instance pairs them and wraps.
        do_reset();
        for (int p = 0; p < P; p++) addr[p] = AW'(1 + 4*p);
        vld = '1;
        for (int i = 0; i < 3; i++) step(1);
        vld = '0; step(1);

        // Stalled bank 2 with port 1 writing addr 6.
        do_reset();
        addr[1] = AW'(6);
        vld = 4'b0010;
        stall = 4'b0100;
        for (int i = 0; i < 3; i++) step(1);
        stall = '0; step(1);
        vld = '0; step(1);

        // Random traffic; a waiting request stays put until both instances take it.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < P; p++) begin
                if (!vld[p] || (last_r0[p] && last_r1[p])) begin
                    vld[p]  = ($urandom_range(0, 3) != 0);
                    addr[p] = AW'($urandom());
                    data[p] = {$urandom(), $urandom()};
                end
            end
            for (int b = 0; b < B; b++) stall[b] = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step(1);
            rst = 1'b0;
        end

        // Saturation: constant conflicts to bank 0 past the counter range.
        do_reset();
        stall = '0;
        for (int p = 0; p < P; p++) addr[p] = '0;
        vld = '1;
        for (int i = 0; i < 70000; i++) step(0);
        for (int i = 0; i < 3; i++) step(1);
        vld = '0;
        step(1); step(1);
        @(negedge clk);
        #1;

        n_chk++;
        if (rq.size() == 0 && oq0.size() == 0 && oq1.size() == 0) n_pass++;
        else $display("FAIL drain: %0d/%0d/%0d records left, required 0", rq.size(), oq0.size(), oq1.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
